// File: rtl/dnn_seq_if.sv
// Host/accelerator-facing signal bundle of the run sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface dnn_seq_if #(
  parameter int RUNS_W = 8,
  parameter int CYC_W  = 64,
  parameter int TMO_W  = 32
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [RUNS_W-1:0] cfg_num_runs;
  logic [TMO_W-1:0]  cfg_timeout;
  logic              abort;
  logic              dnn_start;
  logic              dnn_done;
  logic              busy;
  logic [RUNS_W-1:0] run_idx;
  logic              stat_valid;
  logic [RUNS_W-1:0] stat_run_idx;
  logic [CYC_W-1:0]  stat_cycles;
  logic              stat_timeout;
  logic              seq_done;
  logic              seq_err;
  logic [CYC_W-1:0]  total_cycles;

  modport slave (
    input  cfg_valid, cfg_num_runs, cfg_timeout, abort, dnn_done,
    output cfg_ready, dnn_start, busy, run_idx, stat_valid, stat_run_idx,
           stat_cycles, stat_timeout, seq_done, seq_err, total_cycles
  );

  modport master (
    output cfg_valid, cfg_num_runs, cfg_timeout, abort, dnn_done,
    input  cfg_ready, dnn_start, busy, run_idx, stat_valid, stat_run_idx,
           stat_cycles, stat_timeout, seq_done, seq_err, total_cycles
  );
endinterface

// File: rtl/dnn_run_sequencer.sv
// Launches back-to-back accelerator runs, times each one, and reports per-run and total cycle counts.
// Define DNN_SEQ_TIMEOUT_EN to build the per-run hang timeout; otherwise cfg_timeout is ignored.
module dnn_run_sequencer #(
  parameter int RUNS_W     = 8,
  parameter int CYC_W      = 64,
  parameter int TMO_W      = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dnn_seq_if.slave     bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam int         GAP_W    = 8;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [2:0]        state_reg, state_next;
  logic [RUNS_W-1:0] num_runs_reg, run_idx_reg, stat_run_idx_reg;
  logic [CYC_W-1:0]  run_cnt_reg, total_reg, stat_cycles_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              dnn_start_reg, stat_valid_reg, stat_timeout_reg;
  logic              seq_done_reg, seq_err_reg;
  logic              handshake, last_run, timeout_hit, active, err_set;

  assign handshake = bus.cfg_valid && (state_reg == S_IDLE);
  assign last_run  = (run_idx_reg == num_runs_reg - 1'b1);
  assign active    = (state_reg == S_LAUNCH) || (state_reg == S_WAIT) || (state_reg == S_GAP);

`ifdef DNN_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_reg <= '0;
    end else if (handshake) begin
      tmo_reg <= bus.cfg_timeout;
    end
  end

  assign timeout_hit = (state_reg == S_WAIT) && (tmo_reg != '0) &&
                       (run_cnt_reg >= CYC_W'(tmo_reg));
`else
  assign timeout_hit = 1'b0;
`endif

  // Abort only counts while a run is in flight; a timeout loses to a simultaneous done.
  assign err_set = (bus.abort && active) || (timeout_hit && !bus.dnn_done);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          state_next = (bus.cfg_num_runs == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = bus.abort ? S_FINISH : S_WAIT;
      S_WAIT: begin
        if (bus.dnn_done) begin
          state_next = (bus.abort || last_run) ? S_FINISH : S_GAP;
        end else if (bus.abort || timeout_hit) begin
          state_next = S_FINISH;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_next = S_FINISH;
        end else if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = S_LAUNCH;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      num_runs_reg     <= '0;
      run_idx_reg      <= '0;
      run_cnt_reg      <= '0;
      total_reg        <= '0;
      gap_cnt_reg      <= '0;
      dnn_start_reg    <= 1'b0;
      stat_valid_reg   <= 1'b0;
      stat_run_idx_reg <= '0;
      stat_cycles_reg  <= '0;
      stat_timeout_reg <= 1'b0;
      seq_done_reg     <= 1'b0;
      seq_err_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dnn_start_reg  <= (state_next == S_LAUNCH);
      seq_done_reg   <= (state_next == S_FINISH);
      stat_valid_reg <= 1'b0;

      if (handshake) begin
        num_runs_reg <= bus.cfg_num_runs;
        run_idx_reg  <= '0;
        total_reg    <= '0;
        seq_err_reg  <= 1'b0;
      end
      if (err_set) begin
        seq_err_reg <= 1'b1;
      end
      if (active && (total_reg != CYC_MAX)) begin
        total_reg <= total_reg + 1'b1;
      end

      case (state_reg)
        // Counter holds 1 during the first WAIT cycle so a done there reports one cycle.
        S_LAUNCH: run_cnt_reg <= CYC_W'(1);
        S_WAIT: begin
          gap_cnt_reg <= '0;
          if (run_cnt_reg != CYC_MAX) begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
          if (bus.dnn_done || timeout_hit) begin
            stat_valid_reg   <= 1'b1;
            stat_run_idx_reg <= run_idx_reg;
            stat_cycles_reg  <= run_cnt_reg;
            stat_timeout_reg <= !bus.dnn_done;
          end
        end
        S_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
          if (state_next == S_LAUNCH) begin
            run_idx_reg <= run_idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready    = (state_reg == S_IDLE);
  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.dnn_start    = dnn_start_reg;
  assign bus.run_idx      = run_idx_reg;
  assign bus.stat_valid   = stat_valid_reg;
  assign bus.stat_run_idx = stat_run_idx_reg;
  assign bus.stat_cycles  = stat_cycles_reg;
  assign bus.stat_timeout = stat_timeout_reg;
  assign bus.seq_done     = seq_done_reg;
  assign bus.seq_err      = seq_err_reg;
  assign bus.total_cycles = total_reg;

endmodule

// File: tb/tb_dnn_run_sequencer.sv
// Bench for dnn_run_sequencer: directed vector table, reset corner cases, and randomized
// sequences checked against a cycle-timeline model of the run schedule.
module tb_dnn_run_sequencer;

  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dnn_seq_if bus ();

  dnn_run_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-run done delay (cycles after start); 0 means the accelerator never answers.
  int dly[8];

  // Observed results of one sequence; cycle 1 is the first cycle after the handshake edge.
  int     start_q[$];
  int     st_idx[$];
  longint st_cyc[$];
  bit     st_tmo[$];
  int     done_cyc;
  bit     obs_err;
  longint obs_total;
  int     obs_ridx;

  // Expected results from the timeline model.
  int     e_start[$];
  int     e_idx[$];
  longint e_cyc[$];
  bit     e_tmo[$];
  int     e_done;
  bit     e_err;
  longint e_total;
  int     e_ridx;

  typedef struct {
    int nr;
    int tmo;
    int d;
    int ab;
    int n_starts;
    int n_stats;
    int cyc0;
    bit tmo0;
    bit err;
    int total;
    int ridx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"},    64'(bus.cfg_ready), 64'd1);
    chk({tag, "_busy"},         64'(bus.busy), 64'd0);
    chk({tag, "_dnn_start"},    64'(bus.dnn_start), 64'd0);
    chk({tag, "_run_idx"},      64'(bus.run_idx), 64'd0);
    chk({tag, "_stat_valid"},   64'(bus.stat_valid), 64'd0);
    chk({tag, "_stat_cycles"},  bus.stat_cycles, 64'd0);
    chk({tag, "_stat_timeout"}, 64'(bus.stat_timeout), 64'd0);
    chk({tag, "_seq_done"},     64'(bus.seq_done), 64'd0);
    chk({tag, "_seq_err"},      64'(bus.seq_err), 64'd0);
    chk({tag, "_total"},        bus.total_cycles, 64'd0);
  endtask

  // Drive one configured sequence and record everything the DUT reports until seq_done.
  task automatic run_case(input int nr, input int tmo, input int ab);
    int cyc;
    int done_at;
    bit fin;
    start_q.delete(); st_idx.delete(); st_cyc.delete(); st_tmo.delete();
    done_cyc = -1; obs_err = 1'b0; obs_total = -1; obs_ridx = -1;
    @(negedge clk);
    bus.cfg_valid    = 1'b1;
    bus.cfg_num_runs = 8'(nr);
    bus.cfg_timeout  = 32'(tmo);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("busy_after_cfg",  64'(bus.busy), 64'd1);
    chk("ready_after_cfg", 64'(bus.cfg_ready), 64'd0);
    cyc = 1; done_at = -1; fin = 1'b0;
    while (!fin) begin
      if (bus.dnn_start) begin
        if (start_q.size() < 8 && dly[start_q.size()] > 0) done_at = cyc + dly[start_q.size()];
        else done_at = -1;
        start_q.push_back(cyc);
      end
      if (bus.stat_valid) begin
        st_idx.push_back(int'(bus.stat_run_idx));
        st_cyc.push_back(longint'(bus.stat_cycles));
        st_tmo.push_back(bus.stat_timeout);
      end
      if (bus.seq_done) begin
        fin = 1'b1; done_cyc = cyc; obs_err = bus.seq_err;
        obs_total = longint'(bus.total_cycles); obs_ridx = int'(bus.run_idx);
      end
      bus.dnn_done = (cyc == done_at);
      bus.abort    = (cyc == ab);
      // A second config while busy must be ignored.
      bus.cfg_valid    = (cyc == 2);
      bus.cfg_num_runs = 8'd7;
      if (!fin) begin
        if (cyc >= 3000) begin
          checks++; errors++;
          $display("FAIL cycle_budget: no seq_done after %0d cycles, required within 3000", cyc);
          fin = 1'b1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    bus.dnn_done = 1'b0; bus.abort = 1'b0; bus.cfg_valid = 1'b0;
    $display("seq runs=%0d tmo=%0d abort_at=%0d: starts=%0d stats=%0d done@%0d err=%0d total=%0d run_idx=%0d",
             nr, tmo, ab, start_q.size(), st_cyc.size(), done_cyc, obs_err, obs_total, obs_ridx);
  endtask

  // Timeline model: run r launches at cycle l, ends e cycles later, then GAP idle cycles.
  task automatic model(input int nr, input int tmo, input int ab);
    int l;
    int e;
    bit th;
    e_start.delete(); e_idx.delete(); e_cyc.delete(); e_tmo.delete();
    e_err = 1'b0; e_ridx = 0; e_total = 0; l = 1;
    for (int r = 0; r < nr; r++) begin
      e_ridx = r;
      e_start.push_back(l);
      th = 1'b0;
`ifdef DNN_SEQ_TIMEOUT_EN
      th = (tmo != 0) && (dly[r] == 0 || dly[r] > tmo);
`endif
      e = th ? tmo : dly[r];
      if (ab >= l && ab < l + e) begin e_err = 1'b1; e_total = ab; break; end
      e_idx.push_back(r); e_cyc.push_back(e); e_tmo.push_back(th);
      if (th) begin e_err = 1'b1; e_total = l + e; break; end
      if (ab == l + e) begin e_err = 1'b1; e_total = ab; break; end
      if (r == nr - 1) begin e_total = l + e; break; end
      if (ab > l + e && ab <= l + e + GAP) begin e_err = 1'b1; e_total = ab; break; end
      l = l + e + GAP + 1;
    end
    e_done = int'(e_total) + 1;
  endtask

  task automatic compare_model();
    chk("rnd_n_starts", 64'(start_q.size()), 64'(e_start.size()));
    chk("rnd_n_stats",  64'(st_cyc.size()),  64'(e_cyc.size()));
    for (int i = 0; i < start_q.size() && i < e_start.size(); i++)
      chk("rnd_start_cycle", 64'(start_q[i]), 64'(e_start[i]));
    for (int i = 0; i < st_cyc.size() && i < e_cyc.size(); i++) begin
      chk("rnd_stat_idx",     64'(st_idx[i]), 64'(e_idx[i]));
      chk("rnd_stat_cycles",  64'(st_cyc[i]), 64'(e_cyc[i]));
      chk("rnd_stat_timeout", 64'(st_tmo[i]), 64'(e_tmo[i]));
    end
    chk("rnd_done_cycle", 64'(done_cyc), 64'(e_done));
    chk("rnd_seq_err",    64'(obs_err), 64'(e_err));
    chk("rnd_total",      64'(obs_total), 64'(e_total));
    chk("rnd_run_idx",    64'(obs_ridx), 64'(e_ridx));
  endtask

  initial begin
    int nr, tmo, ab;
    bus.cfg_valid = 1'b0; bus.cfg_num_runs = '0; bus.cfg_timeout = '0;
    bus.abort = 1'b0; bus.dnn_done = 1'b0;

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // done while idle must not produce a stat
    @(negedge clk);
    bus.dnn_done = 1'b1;
    @(negedge clk);
    chk("idle_done_stat", 64'(bus.stat_valid), 64'd0);
    chk("idle_done_busy", 64'(bus.busy), 64'd0);
    bus.dnn_done = 1'b0;

    vecs.push_back('{3, 0, 10, 0, 3, 3, 10, 1'b0, 1'b0, 41, 2});
    vecs.push_back('{0, 0, 10, 0, 0, 0,  0, 1'b0, 1'b0,  0, 0});
    vecs.push_back('{1, 0,  1, 0, 1, 1,  1, 1'b0, 1'b0,  2, 0});
    vecs.push_back('{4, 0,  3, 6, 1, 1,  3, 1'b0, 1'b1,  6, 0});
    vecs.push_back('{2, 0,  2, 8, 2, 1,  2, 1'b0, 1'b1,  8, 1});
    vecs.push_back('{3, 0,  2, 3, 1, 1,  2, 1'b0, 1'b1,  3, 0});
`ifdef DNN_SEQ_TIMEOUT_EN
    vecs.push_back('{2, 5,  0, 0, 1, 1,  5, 1'b1, 1'b1,  6, 0});
    vecs.push_back('{2, 5,  5, 0, 2, 2,  5, 1'b0, 1'b0, 16, 1});
`endif
    for (int v = 0; v < vecs.size(); v++) begin
      for (int i = 0; i < 8; i++) dly[i] = vecs[v].d;
      run_case(vecs[v].nr, vecs[v].tmo, vecs[v].ab);
      chk("vec_n_starts", 64'(start_q.size()), 64'(vecs[v].n_starts));
      chk("vec_n_stats",  64'(st_cyc.size()),  64'(vecs[v].n_stats));
      if (st_cyc.size() > 0 && vecs[v].n_stats > 0) begin
        chk("vec_stat_cycles",  64'(st_cyc[0]), 64'(vecs[v].cyc0));
        chk("vec_stat_timeout", 64'(st_tmo[0]), 64'(vecs[v].tmo0));
        chk("vec_stat_idx0",    64'(st_idx[0]), 64'd0);
      end
      if (vecs[v].ab == 0 && start_q.size() >= 2 && vecs[v].n_starts >= 2)
        chk("vec_start_spacing", 64'(start_q[1] - start_q[0]), 64'(vecs[v].d + GAP + 1));
      chk("vec_seq_err",    64'(obs_err), 64'(vecs[v].err));
      chk("vec_total",      64'(obs_total), 64'(vecs[v].total));
      chk("vec_run_idx",    64'(obs_ridx), 64'(vecs[v].ridx));
      chk("vec_done_cycle", 64'(done_cyc), 64'(vecs[v].total + 1));
    end

    // Reset while dnn_start is high: it must drop without waiting for a clock edge.
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_num_runs = 8'd2; bus.cfg_timeout = '0;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("launch_start_high", 64'(bus.dnn_start), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_launch");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-WAIT with a done pulse arriving during reset.
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_num_runs = 8'd1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(bus.busy), 64'd1);
    chk("wait_total_nonzero", 64'(bus.total_cycles != 0), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    bus.dnn_done = 1'b1;
    @(negedge clk);
    chk("rst_done_stat", 64'(bus.stat_valid), 64'd0);
    @(negedge clk);
    bus.dnn_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int t = 0; t < 40; t++) begin
      nr = int'($urandom_range(0, 5));
`ifdef DNN_SEQ_TIMEOUT_EN
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
`else
      tmo = int'($urandom_range(0, 20));
`endif
      for (int i = 0; i < 8; i++) begin
        dly[i] = int'($urandom_range(1, 20));
`ifdef DNN_SEQ_TIMEOUT_EN
        if (tmo != 0 && $urandom_range(0, 3) == 0) dly[i] = 0;
`endif
      end
      ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 80));
      model(nr, tmo, ab);
      run_case(nr, tmo, ab);
      compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
